// File: rtl/mux_scanner_pkg.sv
// Shared types and sizing constants for the mux_scanner block.
package mux_scanner_pkg;

  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/settle_counter.sv
// Down-counter that times how long the mux address is held before sampling.
module settle_counter
  import mux_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Expires on the last settle cycle so the FSM leaves SETTLE after exactly the loaded count.
  assign o_expired = (r_count == CNT_W'(1));

endmodule

// File: rtl/mux_scanner.sv
// Scans a downstream 4:1 mux and publishes all four samples atomically.
// Optional parity output enabled by defining MUX_SCANNER_PARITY_EN.
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic       done,
  output logic [3:0] data
`ifdef MUX_SCANNER_PARITY_EN
  ,
  output logic       parity
`endif
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in the range 1..15");
  end

  state_e                r_state;
  state_e                w_state_d;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_d;
  logic [NUM_INPUTS-1:0] r_shadow;
  logic [NUM_INPUTS-1:0] r_data;
  logic                  w_cnt_load;
  logic                  w_cnt_en;
  logic                  w_expired;
  logic                  w_sample;
  logic                  w_commit;
  logic                  w_busy;
  logic                  w_done;
  logic [IDX_W-1:0]      w_addr;

  settle_counter u_settle_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(SETTLE_CYCLES)),
    .i_enable   (w_cnt_en),
    .o_expired  (w_expired)
  );

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_sample   = 1'b0;
    w_commit   = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_addr     = r_idx;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        w_addr = '0;
        if (start) begin
          w_state_d  = StSettle;
          w_idx_d    = '0;
          w_cnt_load = 1'b1;
        end
      end
      StSettle: begin
        w_cnt_en = 1'b1;
        if (w_expired) begin
          w_state_d = StSample;
        end
      end
      StSample: begin
        w_sample = 1'b1;
        if (r_idx == IDX_W'(NUM_INPUTS - 1)) begin
          w_state_d = StDone;
        end else begin
          w_idx_d    = r_idx + IDX_W'(1);
          w_cnt_load = 1'b1;
          w_state_d  = StSettle;
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_commit  = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  // Samples land in the shadow first so data only ever shows a complete scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_data   <= '0;
    end else begin
      if (w_sample) begin
        r_shadow[r_idx] <= mux_out;
      end
      if (w_commit) begin
        r_data <= r_shadow;
      end
    end
  end

`ifdef MUX_SCANNER_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_commit) begin
      r_parity <= ^r_shadow;
    end
  end

  assign parity = r_parity;
`endif

  assign address0 = w_addr[0];
  assign address1 = w_addr[1];
  assign busy     = w_busy;
  assign done     = w_done;
  assign data     = r_data;

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 2, setting the number of cycles the address is held before sampling; the legal range is 1..15 and 0 is an elaboration error.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port start  input  1  SHALL request one scan of all four mux inputs.
REQ-005 Port mux_out  input  1  SHALL carry the output of the downstream 4:1 multiplexer.
REQ-006 Port address0  output  1  SHALL drive the mux select LSB.
REQ-007 Port address1  output  1  SHALL drive the mux select MSB.
REQ-008 Port busy  output  1  SHALL be high while a scan is in progress.
REQ-009 Port done  output  1  SHALL give a one-cycle pulse when data is updated.
REQ-010 Port data  output  4  SHALL hold the last completed scan result, with data[i] sampled at select {address1,address0}=i.

Function
REQ-011 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE, with IDLE as the reset state.
REQ-012 IDLE: address=00, busy=0; start=1 SHALL move the FSM to SETTLE with idx=0 and the settle counter loaded.
REQ-013 SETTLE: {address1,address0}=idx and busy=1; after exactly SETTLE_CYCLES cycles in SETTLE the FSM SHALL go to SAMPLE.
REQ-014 SAMPLE: address held; mux_out SHALL be captured into shadow[idx]; if idx==3 go to DONE, else idx+1 and SETTLE.
REQ-015 DONE: data<=shadow as one atomic 4-bit update, done=1 for this cycle only, busy=1, next state IDLE.
REQ-016 Latency: done SHALL be high in the cycle following edge 4*(SETTLE_CYCLES+1)+1 after the edge that samples start (edge 13 for the default).
REQ-017 start SHALL be ignored outside IDLE, including in the DONE cycle; no queuing.
REQ-018 start held high continuously SHALL produce back-to-back scans with one IDLE cycle between them.
REQ-019 data SHALL change only in DONE and SHALL otherwise hold; intermediate shadow values SHALL never be visible on data.
REQ-020 mux_out values of X/Z SHALL be captured unmodified, with no sanitising.
REQ-021 idx SHALL be 2 bits and wraps only via DONE->IDLE->SETTLE, never 3->0 inside a scan.

Reset
REQ-022 reset_n low SHALL, at any time including mid-scan, force state=IDLE, idx=0, counter=0, shadow=0, data=0, done=0, busy=0 and address0=address1=0.
REQ-023 After reset deassertion the first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 With MUX_SCANNER_PARITY_EN defined, the module SHALL add output parity (1 bit), equal to XOR of data[3:0], registered with data in DONE, and reset to 0.
REQ-025 Without MUX_SCANNER_PARITY_EN, no parity port or logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-026 Package mux_scanner_pkg SHALL hold the state enum type, NUM_INPUTS=4, IDX_W=2 and CNT_W=4.
REQ-027 The settle counter SHALL be sub-module settle_counter (load, enable, expired flag); the FSM, shadow and output registers SHALL reside in mux_scanner.

Verification
REQ-028 Reset: assert reset_n=0 mid-SETTLE with data=4'b1010 -> data=0, busy=0, done=0 and address=00 immediately, without waiting for a clock.
REQ-029 Basic scan, SETTLE_CYCLES=2: a behavioural 4:1 mux is attached with in0..in3=1,0,1,1 and start pulses -> done on edge 13 and data=4'b1101.
REQ-030 Address sequence: the address is monitored during the scan -> 00,01,10,11, each held 3 cycles, then 00 in IDLE.
REQ-031 Ignored start: start is re-pulsed at edge 5 and in the DONE cycle -> exactly one done pulse, with the next scan only after a new start in IDLE.
REQ-032 Continuous: start is held high and the inputs change to 0,1,0,0 between scans -> done pulses 14 cycles apart, data goes 4'b1101 then 4'b0010, and data is stable between pulses.
REQ-033 With MUX_SCANNER_PARITY_EN defined and data=4'b0111 -> parity=1; with the macro undefined, the bench compiles without the parity port.
